// File: rtl/rei_pkg.sv
// Shared rei types for the integer multiplier: control word, stage payload and default sizes.
package rei_pkg;

  localparam int XLEN           = 64;
  localparam int MUL_PIPE_DEPTH = 3;
  localparam int MUL_TAG_W      = 5;

  typedef struct packed {
    logic is_mul;
    logic is_src1_signed;
    logic is_src2_signed;
    logic is_high;
    logic is_word;
  } mul_ctrl_s;

  // Operands are held at full package width; narrower builds sign-extend into it losslessly.
  typedef struct packed {
    mul_ctrl_s              ctrl;
    logic [XLEN:0]          sext_src1;
    logic [XLEN:0]          sext_src2;
    logic [MUL_TAG_W-1:0]   tag;
  } mul_req_s;

endpackage

// File: rtl/mul_pipe_if.sv
// Request/response bundle between the issue/writeback logic and the pipelined multiplier.
interface mul_pipe_if #(
  parameter int XLEN  = rei_pkg::XLEN,
  parameter int TAG_W = rei_pkg::MUL_TAG_W
);
  import rei_pkg::*;

  logic              in_valid_i;
  logic              in_ready_o;
  mul_ctrl_s         mul_ctrl_i;
  logic [XLEN-1:0]   src1_i;
  logic [XLEN-1:0]   src2_i;
  logic [TAG_W-1:0]  tag_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [XLEN-1:0]   rslt_o;
  logic [TAG_W-1:0]  tag_o;

  modport slave (
    input  in_valid_i, mul_ctrl_i, src1_i, src2_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, rslt_o, tag_o
  );

  modport master (
    output in_valid_i, mul_ctrl_i, src1_i, src2_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, rslt_o, tag_o
  );

endinterface

// File: rtl/mul_pipe_core.sv
// Signed (XLEN+1)x(XLEN+1) multiply followed by PIPE_DEPTH enable-gated product registers.
module mul_pipe_core #(
  parameter int XLEN       = 64,
  parameter int PIPE_DEPTH = 3
) (
  input  logic                   clk,
  input  logic                   en,
  input  logic signed [XLEN:0]   src1,
  input  logic signed [XLEN:0]   src2,
  output logic signed [2*XLEN+1:0] prod
);
  localparam int PW = 2*XLEN + 2;

  logic signed [PW-1:0] prod_reg [PIPE_DEPTH];

  // No valid logic here so synthesis is free to retime the multiplier across these stages.
  always_ff @(posedge clk) begin
    if (en) begin
      prod_reg[0] <= PW'(src1) * PW'(src2);
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        prod_reg[k] <= prod_reg[k-1];
      end
    end
  end

  assign prod = prod_reg[PIPE_DEPTH-1];

endmodule

// File: rtl/mul_pipe.sv
// Pipelined integer multiplier with valid/ready on both sides, tag pass-through and flush.
// Define REI_MUL_FUSE_EN to add the held-product fast path for repeated operand pairs.
module mul_pipe #(
  parameter int XLEN       = rei_pkg::XLEN,
  parameter int PIPE_DEPTH = rei_pkg::MUL_PIPE_DEPTH,
  parameter int TAG_W      = rei_pkg::MUL_TAG_W
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       flush_i,
  mul_pipe_if.slave  bus
);
  import rei_pkg::*;

  localparam int PW = 2*XLEN + 2;
  localparam int RW = rei_pkg::XLEN + 1;

  if (PIPE_DEPTH < 1) begin : g_bad_depth
    $fatal(1, "mul_pipe: PIPE_DEPTH must be at least 1");
  end
  if ((XLEN != 32 && XLEN != 64) || XLEN > rei_pkg::XLEN || TAG_W > MUL_TAG_W) begin : g_bad_width
    $fatal(1, "mul_pipe: unsupported XLEN/TAG_W");
  end

  logic                          adv;
  logic                          in_ready;
  logic                          accept;
  logic                          take_pipe;
  logic                          out_valid;
  mul_req_s                      req_next;
  mul_req_s                      s0_reg;
  logic [PIPE_DEPTH:0]           valid_reg;
  mul_ctrl_s [PIPE_DEPTH:1]      ctrl_reg;
  logic [PIPE_DEPTH:1][TAG_W-1:0] tag_reg;
  logic signed [PW-1:0]          prod;
  mul_ctrl_s                     out_ctrl;
  logic [PW-1:0]                 out_prod;
  logic [TAG_W-1:0]              out_tag;
  logic [XLEN-1:0]               rslt;

  assign adv      = !out_valid || bus.out_ready_i;
  assign in_ready = adv && !flush_i;
  assign accept   = bus.in_valid_i && in_ready;

  always_comb begin
    req_next           = '0;
    req_next.ctrl      = bus.mul_ctrl_i;
    req_next.sext_src1 = RW'($signed({bus.mul_ctrl_i.is_src1_signed & bus.src1_i[XLEN-1], bus.src1_i}));
    req_next.sext_src2 = RW'($signed({bus.mul_ctrl_i.is_src2_signed & bus.src2_i[XLEN-1], bus.src2_i}));
    req_next.tag       = MUL_TAG_W'(bus.tag_i);
  end

  // Valid bits: bit 0 is S0, bit k is product stage k. Flush clears them even while stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      valid_reg <= '0;
    end else if (adv) begin
      valid_reg[0] <= take_pipe;
      for (int k = 1; k <= PIPE_DEPTH; k++) begin
        valid_reg[k] <= valid_reg[k-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (adv) begin
      s0_reg      <= req_next;
      ctrl_reg[1] <= s0_reg.ctrl;
      tag_reg[1]  <= s0_reg.tag[TAG_W-1:0];
      for (int k = 2; k <= PIPE_DEPTH; k++) begin
        ctrl_reg[k] <= ctrl_reg[k-1];
        tag_reg[k]  <= tag_reg[k-1];
      end
    end
  end

  mul_pipe_core #(
    .XLEN       (XLEN),
    .PIPE_DEPTH (PIPE_DEPTH)
  ) u_core (
    .clk  (clk_i),
    .en   (adv),
    .src1 (s0_reg.sext_src1[XLEN:0]),
    .src2 (s0_reg.sext_src2[XLEN:0]),
    .prod (prod)
  );

`ifdef REI_MUL_FUSE_EN
  logic [PIPE_DEPTH:1][XLEN:0] src1_reg;
  logic [PIPE_DEPTH:1][XLEN:0] src2_reg;
  logic                        hold_valid_reg;
  logic [XLEN:0]               hold_src1_reg;
  logic [XLEN:0]               hold_src2_reg;
  logic [PW-1:0]               hold_prod_reg;
  logic                        byp_valid_reg;
  mul_ctrl_s                   byp_ctrl_reg;
  logic [TAG_W-1:0]            byp_tag_reg;
  logic                        fast;
  logic                        leave;

  assign leave = valid_reg[PIPE_DEPTH] && bus.out_ready_i;
  // Only an empty pipe may be bypassed, so results can never overtake older ops.
  assign fast  = accept && hold_valid_reg && (valid_reg == '0) && !byp_valid_reg &&
                 (req_next.sext_src1[XLEN:0] == hold_src1_reg) &&
                 (req_next.sext_src2[XLEN:0] == hold_src2_reg);
  assign take_pipe = accept && !fast;
  assign out_valid = valid_reg[PIPE_DEPTH] || byp_valid_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      byp_valid_reg  <= 1'b0;
      hold_valid_reg <= 1'b0;
    end else begin
      if (adv)   byp_valid_reg  <= fast;
      if (leave) hold_valid_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (adv) begin
      byp_ctrl_reg <= req_next.ctrl;
      byp_tag_reg  <= bus.tag_i;
      src1_reg[1]  <= s0_reg.sext_src1[XLEN:0];
      src2_reg[1]  <= s0_reg.sext_src2[XLEN:0];
      for (int k = 2; k <= PIPE_DEPTH; k++) begin
        src1_reg[k] <= src1_reg[k-1];
        src2_reg[k] <= src2_reg[k-1];
      end
    end
    if (leave) begin
      hold_src1_reg <= src1_reg[PIPE_DEPTH];
      hold_src2_reg <= src2_reg[PIPE_DEPTH];
      hold_prod_reg <= prod;
    end
  end

  always_comb begin
    out_ctrl = ctrl_reg[PIPE_DEPTH];
    out_prod = prod;
    out_tag  = tag_reg[PIPE_DEPTH];
    if (byp_valid_reg) begin
      out_ctrl = byp_ctrl_reg;
      out_prod = hold_prod_reg;
      out_tag  = byp_tag_reg;
    end
  end
`else
  assign take_pipe = accept;
  assign out_valid = valid_reg[PIPE_DEPTH];
  assign out_ctrl  = ctrl_reg[PIPE_DEPTH];
  assign out_prod  = prod;
  assign out_tag   = tag_reg[PIPE_DEPTH];
`endif

  // High half wins over word mode; a non-multiply op still returns its tag with a zero result.
  always_comb begin
    rslt = '0;
    if (out_ctrl.is_mul) begin
      if (out_ctrl.is_high)      rslt = out_prod[2*XLEN-1:XLEN];
      else if (out_ctrl.is_word) rslt = XLEN'($signed(out_prod[31:0]));
      else                       rslt = out_prod[XLEN-1:0];
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.rslt_o      = rslt;
  assign bus.tag_o       = out_tag;

endmodule

// File: doc/mul_pipe.md
Name: mul_pipe

Overview:
- Next-generation integer multiplier for rei: fully pipelined, one new op per cycle, no `stall_o` counter.
- Adds a valid/ready handshake on both sides, a tag carried through, flush, and synchronous reset.
- Sits in the execute stage beside the ALU. Its output handshake lets writeback back-pressure it; the issue logic uses `in_ready_o` in place of the old stall.

Parameters:
- `XLEN`, `64`: operand/result width (32 or 64; `is_word` is legal only when `XLEN` = 64).
- `PIPE_DEPTH`, `MUL_PIPE_DEPTH` from `rei_pkg` (default 3): number of product register stages; must be ≥1, otherwise `$fatal` at elaboration.
- `TAG_W`, `5`: width of the opaque tag (destination register index) carried with each op.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous active-high reset.
- `flush_i` in 1: kill all in-flight ops.
- `in_valid_i` in 1: request valid.
- `in_ready_o` out 1: request accepted when `in_valid_i` && `in_ready_o`.
- `mul_ctrl_i` in `mul_ctrl_s`: `is_mul`, `is_src1_signed`, `is_src2_signed`, `is_high`, `is_word`.
- `src1_i` in `XLEN`: operand 1.
- `src2_i` in `XLEN`: operand 2.
- `tag_i` in `TAG_W`: request tag.
- `out_valid_o` out 1: result valid.
- `out_ready_i` in 1: consumer accepts result.
- `rslt_o` out `XLEN`: result.
- `tag_o` out `TAG_W`: tag of the result.

Behaviour:
- Interface: one clock `clk_i`; reset `rst_i` is synchronous, active-high.
- Stages:
  - S0 registers the sign-extended (`XLEN`+1)-bit operands, ctrl and tag.
  - S1..S`PIPE_DEPTH` carry the signed (2·`XLEN`+2)-bit product.
  - Each stage has its own valid bit.
- Latency: accept at cycle N → `out_valid_o` at N+`PIPE_DEPTH`+1 if never back-pressured. Throughput is 1 op/cycle.
- Advance: `adv` = !`out_valid_o` || `out_ready_i`. The whole pipe shifts when `adv`=1 and holds every stage when `adv`=0. Bubbles are not compressed.
- `in_ready_o` = `adv` && !`flush_i`. It is combinational from `out_ready_i`; there is no path from `in_valid_i`.
- Output holds stable (`rslt_o`, `tag_o`) while `out_valid_o`=1 and `out_ready_i`=0.
- Sign extension: `src1_i` is sign-extended when `is_src1_signed` is set, otherwise zero-extended; same rule for `src2_i`.
- Result select, decoded at the last stage:
  - `is_high`: `prod[2XLEN-1:XLEN]`.
  - else `is_word`: `prod[31:0]` sign-extended to `XLEN`.
  - else: `prod[XLEN-1:0]`.
  - `is_high` has priority over `is_word`.
  - `is_mul`=0 → `rslt_o`=0, but the op still flows and returns its tag.
- `flush_i`=1: all stage valids clear at the next edge. A request presented in the same cycle is not accepted. `out_valid_o`=0 the cycle after.
- Reset: all valids=0, so `out_valid_o`=0 and `in_ready_o`=1 after reset. Datapath registers are not reset. Reset mid-operation drops every in-flight op.
- Simultaneous flush and reset behave as reset. With `flush_i`=1 and `adv`=0, the output still clears.
- `rslt_o` and `tag_o` are don't-care while `out_valid_o`=0.

Optional Feature:
- Macro: `REI_MUL_FUSE_EN`.
- With the macro defined:
  - A hold register keeps the sign-extended operands and full product of the last op that left the pipe.
  - Fast path: an accepted op whose sign-extended operands equal the hold copy, while all stage valids are 0 and the hold is valid, skips S0..S`PIPE_DEPTH`. It enters a single bypass register and appears on the output after 1 cycle, using the same select logic on the held product. This serves MULH followed by MUL on the same sources.
  - Ordering is preserved because the fast path requires an empty pipe.
  - `flush_i` and `rst_i` invalidate the hold.
- Without the macro: no hold register, and every op takes `PIPE_DEPTH`+1 cycles.

Decomposition:
- `rei_pkg`: `mul_ctrl_s` (existing), `MUL_PIPE_DEPTH`, `XLEN`, and a new `mul_req_s` {ctrl, sext_src1, sext_src2, tag} used for stage payloads.
- Sub-module `mul_pipe_core`:
  - signed (`XLEN`+1)×(`XLEN`+1) multiply followed by `PIPE_DEPTH` enable-gated registers.
  - Retimable; no valid logic inside.
- `mul_pipe` owns handshake, valids, flush, result select and the fuse path.

Test Plan (`XLEN`=64, `PIPE_DEPTH`=3):
- MUL: `src1`=7, `src2`=-3, `out_ready`=1 → `out_valid_o` 4 cycles after accept, `rslt_o`=0xFFFFFFFFFFFFFFEB, tag echoed.
- MULHU: `src1`=`src2`=0xFFFFFFFFFFFFFFFF → `rslt_o`=0xFFFFFFFFFFFFFFFE. MULHSU with the same operands → 0xFFFFFFFFFFFFFFFF. MULW: `src1`=0x80000000, `src2`=1 → 0xFFFFFFFF80000000.
- 6 back-to-back ops with `out_ready_i` low for cycles 5–8:
  - all 6 results emerge in order with no loss or duplication;
  - `in_ready_o` drops exactly while the output is stalled.
- 3 ops in flight, `flush_i` pulsed with `in_valid_i`=1 → that request is not accepted, no `out_valid_o` for any of them, and the next op completes normally at latency 4.
- `rst_i` asserted mid-stream for 1 cycle → `out_valid_o`=0 next cycle, `in_ready_o`=1, no stale results afterwards.
- `REI_MUL_FUSE_EN`: MULH(a,b), then after drain MUL(a,b) → second result at latency 1 and correct; the same sequence with a flush between → latency 4.
